// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, frame marker,
// and state-class helpers used by the loader and its optional byte timer.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // 4 bits wide so it lines up with the core FSM's OutState on debug displays.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SYNC  = 4'd1,
        S_COUNT = 4'd2,
        S_HI    = 4'd3,
        S_LO    = 4'd4,
        S_WRITE = 4'd5,
        S_CSUM  = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    function automatic logic accepts_byte(input state_t s);
        return s inside {S_SYNC, S_COUNT, S_HI, S_LO, S_CSUM};
    endfunction

    // Inside a frame, waiting for the next byte; hunting for sync is not timed.
    function automatic logic is_timed(input state_t s);
        return s inside {S_COUNT, S_HI, S_LO, S_CSUM};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction RAM write port and core-control status of the loader.
// slave = loader side, master = host/testbench side.
interface prog_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              Load_Start;
    logic [7:0]        In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data;
    logic              Mem_Wr;
    logic              CPU_Hold;
    logic              Done;
    logic              Error;
    logic [ADDR_W:0]   Word_Count;

    modport slave (
        input  Load_Start, In_Data, In_Valid,
        output In_Ready, Mem_Addr, Mem_Data, Mem_Wr, CPU_Hold, Done, Error, Word_Count
    );

    modport master (
        output Load_Start, In_Data, In_Valid,
        input  In_Ready, Mem_Addr, Mem_Data, Mem_Wr, CPU_Hold, Done, Error, Word_Count
    );
endinterface

// File: rtl/prog_loader_byte_timer.sv
// Inter-byte watchdog for the loader (built only with PROG_LOADER_TIMEOUT_EN).
// Latency: expired asserts on the TIMEOUT_CYC-th consecutive idle cycle while run is high.
// Backpressure: none; clr (an accepted byte) or a drop of run restarts the count.
module byte_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = run && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Loads a SYNC/N/words/CSUM frame into instruction RAM, holding the core until the checksum verifies.
// Latency: Mem_Wr one cycle after the low byte; Done/CPU_Hold one cycle after CSUM. PROG_LOADER_TIMEOUT_EN adds an inter-byte timeout.
// Backpressure: In_Ready drops for one bubble per word (S_WRITE) and outside a frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter int         DATA_W      = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    prog_loader_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        acc_q, acc_d;
    logic              hold_q, hold_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              byte_ok;
    logic              timeout;

    assign byte_ok = bus.In_Valid && in_ready_q;

`ifdef PROG_LOADER_TIMEOUT_EN
    byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_byte_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .run     (is_timed(state_q)),
        .clr     (byte_ok),
        .expired (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wc_d    = wc_q;
        n_d     = n_q;
        acc_d   = acc_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.Load_Start) begin
                    state_d = S_SYNC;
                    hold_d  = 1'b1;
                    wc_d    = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            S_SYNC: begin
                if (byte_ok && bus.In_Data == SYNC_BYTE) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (byte_ok) begin
                    n_d     = (bus.In_Data == 8'h00) ? DEPTH : (ADDR_W+1)'(bus.In_Data);
                    acc_d   = acc_q ^ bus.In_Data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (byte_ok) begin
                    data_d[DATA_W-1 -: 8] = bus.In_Data;
                    acc_d   = acc_q ^ bus.In_Data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (byte_ok) begin
                    data_d[7:0] = bus.In_Data;
                    acc_d   = acc_q ^ bus.In_Data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // For N=128 the address wraps to 0 here, after the final write.
                addr_d  = addr_q + ADDR_W'(1);
                wc_d    = wc_q + (ADDR_W+1)'(1);
                state_d = (wc_d == n_q) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (byte_ok) begin
                    if (bus.In_Data == acc_q) begin
                        state_d = S_DONE;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_ERR;
        in_ready_d = accepts_byte(state_d);
        mem_wr_d   = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wc_q       <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            hold_q     <= 1'b0;
            in_ready_q <= 1'b0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wc_q       <= wc_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.In_Ready   = in_ready_q;
    assign bus.Mem_Addr   = addr_q;
    assign bus.Mem_Data   = data_q;
    assign bus.Mem_Wr     = mem_wr_q;
    assign bus.CPU_Hold   = hold_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.Word_Count = wc_q;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader; expected writes and outcome come from a frame parser model.
`timescale 1ns/1ps
module tb_prog_loader;
`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1000;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(7), .DATA_W(16)) bus();

    prog_loader #(
        .ADDR_W(7), .DATA_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [22:0] wr_obs[$];
    logic [22:0] wr_exp[$];
    bit          exp_ok;
    int          exp_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.Mem_Wr === 1'b1) wr_obs.push_back({bus.Mem_Addr, bus.Mem_Data});
    end

    // Reference: parse the byte stream as a frame and list the writes it implies.
    task automatic model_frame(input byte_q_t s);
        int         i = 0;
        logic [7:0] acc;
        wr_exp.delete();
        while (i < s.size() && s[i] != 8'hA5) i++;
        i++;
        exp_n = (s[i] == 8'h00) ? 128 : int'(s[i]);
        acc   = s[i];
        i++;
        for (int k = 0; k < exp_n; k++) begin
            wr_exp.push_back({7'(k), s[i], s[i+1]});
            acc = acc ^ s[i] ^ s[i+1];
            i += 2;
        end
        exp_ok = (s[i] == acc);
    endtask

    task automatic pulse_start();
        bus.Load_Start = 1'b1;
        @(posedge clk); #1;
        bus.Load_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited = 0;
        bus.In_Valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin
            bus.In_Data = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.In_Data  = b;
        bus.In_Valid = 1'b1;
        while (!bus.In_Ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.In_Ready) begin
            @(posedge clk); #1;
        end else begin
            check_eq("accept_bound", 32'(bus.In_Ready), 32'd1);
        end
        bus.In_Valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input byte_q_t s, input int mid_start, input int max_gap);
        model_frame(s);
        pulse_start();
        check_eq({tag, "_hold_armed"}, 32'(bus.CPU_Hold), 32'd1);
        check_eq({tag, "_flags_clr"}, 32'({bus.Done, bus.Error}), 32'd0);
        check_eq({tag, "_wc_clr"}, 32'(bus.Word_Count), 32'd0);
        wr_obs.delete();
        for (int k = 0; k < s.size(); k++) begin
            if (k == mid_start) pulse_start();
            send_byte(s[k], max_gap);
        end
        check_eq({tag, "_done"}, 32'(bus.Done), 32'(exp_ok));
        check_eq({tag, "_error"}, 32'(bus.Error), 32'(!exp_ok));
        check_eq({tag, "_hold"}, 32'(bus.CPU_Hold), 32'(!exp_ok));
        check_eq({tag, "_wc"}, 32'(bus.Word_Count), 32'(exp_n));
        check_eq({tag, "_addr"}, 32'(bus.Mem_Addr), 32'(7'(exp_n)));
        check_eq({tag, "_nwr"}, 32'(wr_obs.size()), 32'(wr_exp.size()));
        for (int k = 0; k < wr_exp.size() && k < wr_obs.size(); k++)
            check_eq({tag, "_wr"}, 32'(wr_obs[k]), 32'(wr_exp[k]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t f;
        byte_q_t good;
        logic [7:0] acc;
        logic [7:0] g;
        int         n;

        bus.Load_Start = 1'b0;
        bus.In_Data    = 8'h00;
        bus.In_Valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus.In_Ready), 32'd0);
        check_eq("rst_mem_wr", 32'(bus.Mem_Wr), 32'd0);
        check_eq("rst_hold", 32'(bus.CPU_Hold), 32'd0);
        check_eq("rst_done", 32'(bus.Done), 32'd0);
        check_eq("rst_error", 32'(bus.Error), 32'd0);
        check_eq("rst_wc", 32'(bus.Word_Count), 32'd0);
        check_eq("rst_addr", 32'(bus.Mem_Addr), 32'd0);
        check_eq("rst_data", 32'(bus.Mem_Data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        good = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame("basic", good, -1, 0);
        f = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        run_frame("badcsum", f, -1, 1);
        run_frame("rearm", good, -1, 2);
        f = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h0F, 8'h0E};
        run_frame("garbage", f, -1, 3);
        run_frame("midstart", good, 4, 0);

        f = '{8'hA5, 8'h00};
        acc = 8'h00;
        for (int k = 0; k < 128; k++) begin
            f.push_back(8'h00);
            f.push_back(8'(k));
            acc ^= 8'(k);
        end
        f.push_back(acc);
        run_frame("full128", f, -1, 0);

        for (int t = 0; t < 12; t++) begin
            f = {};
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                f.push_back(g);
            end
            n = $urandom_range(24, 1);
            f.push_back(8'hA5);
            f.push_back(8'(n));
            acc = 8'(n);
            for (int k = 0; k < 2 * n; k++) begin
                g = 8'($urandom);
                f.push_back(g);
                acc ^= g;
            end
            if ($urandom_range(3, 0) == 0) acc ^= 8'($urandom_range(255, 1));
            f.push_back(acc);
            run_frame("rand", f, -1, int'($urandom_range(3, 0)));
        end

        // Reset in the middle of a 5-word frame, then a clean reload.
        pulse_start();
        f = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int k = 0; k < f.size(); k++) send_byte(f[k], 1);
        @(posedge clk); #1;
        check_eq("pre_rst_wc", 32'(bus.Word_Count), 32'd3);
        check_eq("pre_rst_hold", 32'(bus.CPU_Hold), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hold", 32'(bus.CPU_Hold), 32'd0);
        check_eq("arst_done", 32'(bus.Done), 32'd0);
        check_eq("arst_wc", 32'(bus.Word_Count), 32'd0);
        check_eq("arst_addr", 32'(bus.Mem_Addr), 32'd0);
        check_eq("arst_ready", 32'(bus.In_Ready), 32'd0);
        check_eq("arst_flags", 32'({bus.Mem_Wr, bus.Error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("post_rst", good, -1, 1);

`ifdef PROG_LOADER_TIMEOUT_EN
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        repeat (TMO - 1) begin
            @(posedge clk); #1;
        end
        check_eq("tmo_not_yet", 32'(bus.Error), 32'd0);
        @(posedge clk); #1;
        check_eq("tmo_error", 32'(bus.Error), 32'd1);
        check_eq("tmo_hold", 32'(bus.CPU_Hold), 32'd1);
        pulse_start();
        repeat (500) begin
            @(posedge clk); #1;
        end
        check_eq("sync_no_tmo", 32'(bus.Error), 32'd0);
        check_eq("sync_ready", 32'(bus.In_Ready), 32'd1);
        run_frame("after_sync_wait", good, -1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
